// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (optional perf counters via HAZ_PERF_CNT_EN)
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYC = 2,
    parameter int WAIT_MAX  = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic             dm_req,
    input  logic             dm_ready,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_flushes,
    output logic [CNT_W-1:0] perf_mem_waits,
`endif
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             wb_bubble,
    output logic             dm_timeout,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01, MEM_WAIT = 2'b10} state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYC - 1);

    state_t           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             mem_stall, load_use, redir_acc, lu_cyc;

    assign mem_stall = dm_req & ~dm_ready;
    assign load_use  = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Next-state and Mealy outputs; memory wait beats redirect beats load-use, reset blanks all outputs
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        redir_acc   = 1'b0;
        lu_cyc      = 1'b0;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_hold  = 1'b0;
        wb_bubble   = 1'b0;
        case (state_q)
            RUN, FLUSH: begin
                if (mem_stall) begin
                    {pc_hold, ifid_hold, exmem_hold, wb_bubble} = 4'hf;
                    wait_cnt_d = CNT_W'(1);
                    state_d    = MEM_WAIT;
                    if (ex_redirect) begin
                        flush_cnt_d = FLUSH_RELOAD;
                        redir_acc   = 1'b1;
                    end
                end else if (ex_redirect || state_q == FLUSH) begin
                    {ifid_flush, idex_flush} = 2'b11;
                    redir_acc   = ex_redirect;
                    flush_cnt_d = ex_redirect ? FLUSH_RELOAD : flush_cnt_q - 4'd1;
                    state_d     = (flush_cnt_d != 4'd0) ? FLUSH : RUN;
                end else if (load_use) begin
                    {pc_hold, ifid_hold, idex_flush} = 3'b111;
                    lu_cyc = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    wait_cnt_d = '0;
                    state_d    = (flush_cnt_q != 4'd0) ? FLUSH : RUN;
                end else begin
                    {pc_hold, ifid_hold, exmem_hold, wb_bubble} = 4'hf;
                    if (wait_cnt_q == CNT_W'(WAIT_MAX)) begin
                        timeout_d   = 1'b1;
                        wait_cnt_d  = '0;
                        flush_cnt_d = 4'd0;
                        state_d     = RUN;
                    end else begin
                        wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            {pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold, wb_bubble} = 6'b0;
            redir_acc = 1'b0;
            lu_cyc    = 1'b0;
        end
        dm_timeout = timeout_q & ~rst;
        state_o    = rst ? RUN : state_q;
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] lu_q, fl_q, mw_q;

    assign perf_lu_stalls = lu_q;
    assign perf_flushes   = fl_q;
    assign perf_mem_waits = mw_q;

    // Saturating event counters for load-use cycles, accepted redirects and memory-wait cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_q <= '0;
            fl_q <= '0;
            mw_q <= '0;
        end else begin
            if (lu_cyc && !(&lu_q)) lu_q <= lu_q + CNT_W'(1);
            if (redir_acc && !(&fl_q)) fl_q <= fl_q + CNT_W'(1);
            if (state_q == MEM_WAIT && !(&mw_q)) mw_q <= mw_q + CNT_W'(1);
        end
    end
`else
    logic unused_perf;
    assign unused_perf = redir_acc ^ lu_cyc;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (FLUSH_CYC=2, WAIT_MAX=4)
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst, ex_memread, ex_redirect, dm_req, dm_ready;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold, wb_bubble, dm_timeout;
    logic [1:0] state_o;
    logic [8:0] exp_q[$];
    int         total = 0;
    int         fails = 0;

    // Expected output vectors {pc_hold,ifid_hold,ifid_flush,idex_flush,exmem_hold,wb_bubble,dm_timeout,state_o}
    localparam logic [8:0] IDLE = 9'b000000000;
    localparam logic [8:0] LU   = 9'b110100000;
    localparam logic [8:0] FL0  = 9'b001100000;
    localparam logic [8:0] FL1  = 9'b001100001;
    localparam logic [8:0] MW0  = 9'b110011000;
    localparam logic [8:0] MW1  = 9'b110011010;
    localparam logic [8:0] REL  = 9'b000000010;
    localparam logic [8:0] TO   = 9'b000000100;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYC(2), .WAIT_MAX(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect), .dm_req(dm_req), .dm_ready(dm_ready),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_hold(exmem_hold), .wb_bubble(wb_bubble), .dm_timeout(dm_timeout), .state_o(state_o)
    );

    task automatic step(input string tag, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic redir, input logic req,
                        input logic rdy, input logic [8:0] e);
        logic [8:0] got, want;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_memread = mr; ex_redirect = redir; dm_req = req; dm_ready = rdy;
        exp_q.push_back(e);
        #3;
        got  = {pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold, wb_bubble, dm_timeout, state_o};
        want = exp_q.pop_front();
        total++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%b exp=%b", tag, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_rst(input string tag);
        step(tag, 1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), IDLE);
    endtask

    initial begin
        {rst, ex_memread, ex_redirect, dm_req, dm_ready} = 5'b10000;
        {id_rs1, id_rs2, ex_rd} = '0;
        @(posedge clk);
        #1;
        rnd_rst("rst0");
        rnd_rst("rst1");
        step("idle",      0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("lu_rs2",    0, 1, 5, 5, 1, 0, 0, 0, LU);
        step("lu_done",   0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("lu_rs1",    0, 7, 2, 7, 1, 0, 0, 0, LU);
        step("lu_rd0",    0, 0, 0, 0, 1, 0, 0, 0, IDLE);
        step("lu_nold",   0, 5, 5, 5, 0, 0, 0, 0, IDLE);
        step("redir",     0, 0, 0, 0, 0, 1, 0, 0, FL0);
        step("flush2",    0, 0, 0, 0, 0, 0, 0, 0, FL1);
        step("flush_end", 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("redir_b",   0, 0, 0, 0, 0, 1, 0, 0, FL0);
        step("fl_lu_ign", 0, 3, 3, 3, 1, 0, 0, 0, FL1);
        step("fl_b_end",  0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("mw_c0",     0, 0, 0, 0, 0, 0, 1, 0, MW0);
        step("mw_c1",     0, 0, 0, 0, 0, 0, 1, 0, MW1);
        step("mw_c2",     0, 0, 0, 0, 0, 1, 1, 0, MW1);
        step("mw_ready",  0, 0, 0, 0, 0, 0, 1, 1, REL);
        step("mw_after",  0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("rd_mw_c0",  0, 0, 0, 0, 0, 1, 1, 0, MW0);
        step("rd_mw_c1",  0, 0, 0, 0, 0, 0, 1, 0, MW1);
        step("rd_ready",  0, 0, 0, 0, 0, 0, 1, 1, REL);
        step("rd_flush",  0, 0, 0, 0, 0, 0, 0, 0, FL1);
        step("rd_run",    0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        step("to_c0",     0, 0, 0, 0, 0, 0, 1, 0, MW0);
        for (int i = 1; i <= 4; i++) step($sformatf("to_c%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, MW1);
        step("to_flag",   0, 0, 0, 0, 0, 0, 1, 0, MW0 | TO);
        step("to_rel",    0, 0, 0, 0, 0, 0, 0, 0, REL | TO);
        step("to_sticky", 0, 0, 0, 0, 0, 0, 0, 0, TO);
        step("to_lu",     0, 9, 1, 9, 1, 0, 0, 0, LU | TO);
        rnd_rst("to_rst");
        step("post_rst",  0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
